// File: rtl/boreal_adc_frame_rx_if.sv
// Bus bundle for the ADC frame receiver: SPI pins towards the ADC plus the
// per-channel word beat and status strobes towards the cursor top level.
interface boreal_adc_frame_rx_if;
    logic        en;
    logic        drdy_n;
    logic        miso;
    logic        cs_n;
    logic        sclk;
    logic [23:0] raw_adc_out;
    logic [2:0]  adc_channel_sel;
    logic        adc_data_ready;
    logic        frame_done;
    logic        hdr_err;
    logic        overrun;
    logic [7:0]  err_count;
    logic        busy;

    // Receiver side: drives the SPI master pins and the word beat.
    modport master (
        input  en, drdy_n, miso,
        output cs_n, sclk, raw_adc_out, adc_channel_sel, adc_data_ready,
               frame_done, hdr_err, overrun, err_count, busy
    );

    // ADC / environment side.
    modport slave (
        output en, drdy_n, miso,
        input  cs_n, sclk, raw_adc_out, adc_channel_sel, adc_data_ready,
               frame_done, hdr_err, overrun, err_count, busy
    );
endinterface

// File: rtl/boreal_adc_frame_rx.sv
// SPI frame receiver for the 8-channel EEG ADC. On a data-ready fall it reads
// one status word plus NUM_CH channel words (24 bits each, MSB first), checks
// the status header and emits each channel word as a one-cycle beat.
module boreal_adc_frame_rx #(
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned NUM_CH  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    boreal_adc_frame_rx_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_HIGH,
        S_LOW,
        S_HOLD,
        S_GAP
    } state_t;

    localparam logic [7:0] DIV_LAST  = 8'(CLK_DIV - 1);
    localparam logic [3:0] LAST_WORD = 4'(NUM_CH);
    localparam logic [4:0] LAST_BIT  = 5'd23;
    localparam logic [3:0] HDR_MAGIC = 4'hC;

    // drdy_n synchronizer and edge detector
    logic sync1_q, sync2_q, dly_q;
    logic drdy_fall;

    // FSM and datapath state
    state_t      state_q, state_d;
    logic [7:0]  div_q, div_d;
    logic [4:0]  bit_q, bit_d;
    logic [3:0]  word_q, word_d;
    logic [23:0] shift_q, shift_d;
    logic        last_bit_q, last_bit_d;
    logic        word_done_q, word_done_d;
    logic        frame_bad_q, frame_bad_d;

    // Registered outputs
    logic        cs_n_q, cs_n_d;
    logic        sclk_q, sclk_d;
    logic        busy_q, busy_d;
    logic [23:0] raw_q, raw_d;
    logic [2:0]  sel_q, sel_d;
    logic        rdy_q, rdy_d;
    logic        done_q, done_d;
    logic        hdr_err_q, hdr_err_d;
    logic        overrun_q, overrun_d;
    logic [7:0]  err_q, err_d;

    logic div_end;

    // Two-flop synchronizer plus one delay flop for falling-edge detection
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            dly_q   <= 1'b1;
        end else begin
            sync1_q <= bus.drdy_n;
            sync2_q <= sync1_q;
            dly_q   <= sync2_q;
        end
    end

    assign drdy_fall = dly_q & ~sync2_q;
    assign div_end   = (div_q == DIV_LAST);

    // State, counters and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            div_q       <= '0;
            bit_q       <= '0;
            word_q      <= '0;
            shift_q     <= '0;
            last_bit_q  <= 1'b0;
            word_done_q <= 1'b0;
            frame_bad_q <= 1'b0;
            cs_n_q      <= 1'b1;
            sclk_q      <= 1'b0;
            busy_q      <= 1'b0;
            raw_q       <= '0;
            sel_q       <= '0;
            rdy_q       <= 1'b0;
            done_q      <= 1'b0;
            hdr_err_q   <= 1'b0;
            overrun_q   <= 1'b0;
            err_q       <= '0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            bit_q       <= bit_d;
            word_q      <= word_d;
            shift_q     <= shift_d;
            last_bit_q  <= last_bit_d;
            word_done_q <= word_done_d;
            frame_bad_q <= frame_bad_d;
            cs_n_q      <= cs_n_d;
            sclk_q      <= sclk_d;
            busy_q      <= busy_d;
            raw_q       <= raw_d;
            sel_q       <= sel_d;
            rdy_q       <= rdy_d;
            done_q      <= done_d;
            hdr_err_q   <= hdr_err_d;
            overrun_q   <= overrun_d;
            err_q       <= err_d;
        end
    end

    // Next-state, bit capture, word processing and error accounting
    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        bit_d       = bit_q;
        word_d      = word_q;
        shift_d     = shift_q;
        last_bit_d  = last_bit_q;
        word_done_d = 1'b0;
        frame_bad_d = frame_bad_q;
        raw_d       = raw_q;
        sel_d       = sel_q;
        rdy_d       = 1'b0;
        done_d      = 1'b0;
        hdr_err_d   = 1'b0;
        overrun_d   = 1'b0;
        err_d       = err_q;

        case (state_q)
            S_IDLE: begin
                div_d = '0;
                if (drdy_fall && bus.en) begin
                    state_d     = S_SETUP;
                    bit_d       = '0;
                    word_d      = '0;
                    last_bit_d  = 1'b0;
                    frame_bad_d = 1'b0;
                end
            end
            S_SETUP: begin
                if (div_end) begin
                    state_d = S_HIGH;
                    div_d   = '0;
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            S_HIGH: begin
                if (div_end) begin
                    shift_d = {shift_q[22:0], bus.miso};
                    state_d = S_LOW;
                    div_d   = '0;
                    if (bit_q == LAST_BIT) begin
                        bit_d       = '0;
                        word_done_d = 1'b1;
                        if (word_q == LAST_WORD) begin
                            last_bit_d = 1'b1;
                        end
                    end else begin
                        bit_d = bit_q + 5'd1;
                    end
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            S_LOW: begin
                if (div_end) begin
                    state_d = last_bit_q ? S_HOLD : S_HIGH;
                    div_d   = '0;
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            S_HOLD: begin
                if (div_end) begin
                    state_d = S_GAP;
                    div_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            S_GAP: begin
                if (div_end) begin
                    state_d = S_IDLE;
                    div_d   = '0;
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                div_d   = '0;
            end
        endcase

        // A completed word is handled one cycle after its last bit lands; the
        // word index advances here so it still names the finished word.
        if (word_done_q) begin
            if (word_q == '0) begin
                if (shift_q[23:20] != HDR_MAGIC) begin
                    hdr_err_d   = 1'b1;
                    frame_bad_d = 1'b1;
                end
            end else if (!frame_bad_q) begin
                raw_d = shift_q;
                sel_d = 3'(word_q - 4'd1);
                rdy_d = 1'b1;
            end
            if (word_q != LAST_WORD) begin
                word_d = word_q + 4'd1;
            end
        end

        if (drdy_fall && (state_q != S_IDLE)) begin
            overrun_d = 1'b1;
        end

        if ((hdr_err_q || overrun_q) && (err_q != 8'hFF)) begin
            err_d = err_q + 8'd1;
        end

        cs_n_d = !((state_d == S_SETUP) || (state_d == S_HIGH) ||
                   (state_d == S_LOW)   || (state_d == S_HOLD));
        sclk_d = (state_d == S_HIGH);
        busy_d = (state_d != S_IDLE);
    end

    assign bus.cs_n            = cs_n_q;
    assign bus.sclk            = sclk_q;
    assign bus.busy            = busy_q;
    assign bus.raw_adc_out     = raw_q;
    assign bus.adc_channel_sel = sel_q;
    assign bus.adc_data_ready  = rdy_q;
    assign bus.frame_done      = done_q;
    assign bus.hdr_err         = hdr_err_q;
    assign bus.overrun         = overrun_q;
    assign bus.err_count       = err_q;

endmodule
